// File: rtl/oam_dma_loader.sv
// Sprite-DMA engine: on a CPU write of page P to TRIG_ADDR, copies LEN bytes from P:00.. into the RAM
// write port while holding the CPU stalled, using alternating read/write cycles with optional parity alignment.
module oam_dma_loader #(
    parameter int unsigned        ADDR_W    = 15,
    parameter logic [ADDR_W-1:0]  DEST_BASE = '0,
    parameter int unsigned        LEN       = 256,
    parameter logic [15:0]        TRIG_ADDR = 16'h4014
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_rdy,
    output logic              busy,
    output logic              src_re,
    output logic [15:0]       src_addr,
    input  logic [7:0]        src_data,
    output logic              we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    localparam logic [7:0] LAST = 8'(LEN - 1);

    state_t            state;
    logic [7:0]        idx;
    logic [7:0]        page;
    logic [7:0]        data;
    logic              phase;
    logic              trigger;
    logic [ADDR_W-1:0] idx_ext;

    assign trigger = cpu_we && (cpu_addr == TRIG_ADDR);
    assign idx_ext = ADDR_W'(idx);
    assign w_data  = data;

    // Outputs are registered alongside the state so each one is valid for exactly the state it belongs to.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            page     <= '0;
            data     <= '0;
            phase    <= 1'b0;
            cpu_rdy  <= 1'b1;
            busy     <= 1'b0;
            src_re   <= 1'b0;
            src_addr <= '0;
            we       <= 1'b0;
            w_addr   <= '0;
        end else begin
            phase <= ~phase;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        page    <= cpu_wdata;
                        idx     <= '0;
                        state   <= HALT;
                        cpu_rdy <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                HALT: begin
                    if (phase) begin
                        state <= ALIGN;
                    end else begin
                        state    <= READ;
                        src_re   <= 1'b1;
                        src_addr <= {page, idx};
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    src_re   <= 1'b1;
                    src_addr <= {page, idx};
                end
                READ: begin
                    data   <= src_data;
                    state  <= WRITE;
                    src_re <= 1'b0;
                    we     <= 1'b1;
                    w_addr <= DEST_BASE + idx_ext;
                end
                WRITE: begin
                    we <= 1'b0;
                    if (idx == LAST) begin
                        state   <= IDLE;
                        cpu_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= READ;
                        src_re   <= 1'b1;
                        src_addr <= {page, idx + 8'd1};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
